// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and legality check
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - combinational integer ALU evaluating one control code
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result  = '0;
    illegal = !is_legal_op(op);
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][3:0]       req_op,
  input  logic [1:0][XLEN-1:0]  req_a,
  input  logic [1:0][XLEN-1:0]  req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_result,
  output logic                  rsp_src,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  rsp_illegal
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             src_q, src_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             illegal_q, illegal_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic [1:0]       grant;
  logic             sel;
  logic             accept;
  logic [XLEN-1:0]  exec_result;
  logic             exec_illegal;

  // Contention goes to whichever requester was not served last.
  assign grant[0]   = req_valid[0] && (!req_valid[1] || last_grant_q);
  assign grant[1]   = req_valid[1] && (!req_valid[0] || !last_grant_q);
  assign can_accept = !flush && (!rsp_valid_q || rsp_ready);
  assign req_ready  = can_accept ? grant : 2'b00;
  assign accept     = |req_ready;
  assign sel        = grant[1];

  alu_exec #(.XLEN(XLEN)) u_exec (
    .op      (req_op[sel]),
    .a       (req_a[sel]),
    .b       (req_b[sel]),
    .result  (exec_result),
    .illegal (exec_illegal)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    result_d     = result_q;
    src_d        = src_q;
    tag_d        = tag_q;
    illegal_d    = illegal_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d  = 1'b1;
      result_d     = exec_result;
      src_d        = sel;
      tag_d        = req_tag[sel];
      illegal_d    = exec_illegal;
      last_grant_d = sel;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      result_q     <= '0;
      src_q        <= 1'b0;
      tag_q        <= '0;
      illegal_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      result_q     <= result_d;
      src_q        <= src_d;
      tag_q        <= tag_d;
      illegal_q    <= illegal_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_src     = src_q;
  assign rsp_tag     = tag_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int XLEN  = 64;
  localparam int TAG_W = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][3:0]       req_op;
  logic [1:0][XLEN-1:0]  req_a;
  logic [1:0][XLEN-1:0]  req_b;
  logic [1:0][TAG_W-1:0] req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_result;
  logic                  rsp_src;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_src     (rsp_src),
    .rsp_tag     (rsp_tag),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [63:0] res, input logic src,
                         input logic [3:0] t, input logic ill);
    chk({tag, ".valid"}, {63'd0, rsp_valid}, 64'd1);
    chk({tag, ".result"}, rsp_result, res);
    chk({tag, ".src"}, {63'd0, rsp_src}, {63'd0, src});
    chk({tag, ".tag"}, {60'd0, rsp_tag}, {60'd0, t});
    chk({tag, ".illegal"}, {63'd0, rsp_illegal}, {63'd0, ill});
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] t);
    req_op[i]  = op;
    req_a[i]   = a;
    req_b[i]   = b;
    req_tag[i] = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;

    // reset state
    tick();
    chk("rst.valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst.result", rsp_result, 64'd0);
    chk("rst.src", {63'd0, rsp_src}, 64'd0);
    chk("rst.tag", {60'd0, rsp_tag}, 64'd0);
    chk("rst.illegal", {63'd0, rsp_illegal}, 64'd0);
    rst_n = 1'b1;

    // single requester 0: ADD 5+7
    set_req(0, 4'b0010, 64'd5, 64'd7, 4'd3);
    req_valid = 2'b01;
    #1 chk("add.ready", {62'd0, req_ready}, 64'd1);
    tick();
    chk_rsp("add", 64'd12, 1'b0, 4'd3, 1'b0);

    // contention alternates: last_grant=0 so requester 1 first
    set_req(0, 4'b0110, 64'd0, 64'd1, 4'd1);
    set_req(1, 4'b1011, 64'h8000_0000_0000_0000, 64'd63, 4'd2);
    req_valid = 2'b11;
    #1 chk("rr1.ready", {62'd0, req_ready}, 64'd2);
    tick();
    chk_rsp("sra", ONES, 1'b1, 4'd2, 1'b0);
    chk("rr2.ready", {62'd0, req_ready}, 64'd1);
    tick();
    chk_rsp("sub", ONES, 1'b0, 4'd1, 1'b0);
    chk("rr3.ready", {62'd0, req_ready}, 64'd2);

    // backpressure for 3 cycles
    rsp_ready = 1'b0;
    set_req(0, 4'b0010, 64'd1, 64'd2, 4'd4);
    set_req(1, 4'b1000, 64'hFF, 64'h0F, 4'd5);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.ready", {62'd0, req_ready}, 64'd0);
      tick();
      chk_rsp("bp.hold", ONES, 1'b0, 4'd1, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp.release.ready", {62'd0, req_ready}, 64'd2);
    tick();
    chk_rsp("xor", 64'hF0, 1'b1, 4'd5, 1'b0);

    // compares, shift-by-64 wraps to 0
    req_valid = 2'b01;
    set_req(0, 4'b0111, ONES, 64'd1, 4'd6);
    tick();
    chk_rsp("slt", 64'd1, 1'b0, 4'd6, 1'b0);
    req_valid = 2'b10;
    set_req(1, 4'b1100, ONES, 64'd1, 4'd7);
    tick();
    chk_rsp("sltu", 64'd0, 1'b1, 4'd7, 1'b0);
    req_valid = 2'b01;
    set_req(0, 4'b1001, 64'h123, 64'd64, 4'd8);
    tick();
    chk_rsp("sll64", 64'h123, 1'b0, 4'd8, 1'b0);

    // illegal op 1111 on requester 1 (last_grant=0)
    req_valid = 2'b11;
    set_req(0, 4'b0010, 64'd1, 64'd2, 4'd4);
    set_req(1, 4'b1111, 64'd5, 64'd5, 4'd9);
    #1 chk("ill.ready", {62'd0, req_ready}, 64'd2);
    tick();
    chk_rsp("ill", 64'd0, 1'b1, 4'd9, 1'b1);
    chk("ill.advance", {62'd0, req_ready}, 64'd1);

    // flush beats rsp_ready
    flush = 1'b1;
    #1 chk("flush.ready", {62'd0, req_ready}, 64'd0);
    tick();
    chk("flush.valid", {63'd0, rsp_valid}, 64'd0);
    chk("flush.result", rsp_result, 64'd0);
    chk("flush.tag", {60'd0, rsp_tag}, 64'd9);
    flush = 1'b0;
    #1 chk("postflush.ready", {62'd0, req_ready}, 64'd1);
    tick();
    chk_rsp("postflush", 64'd3, 1'b0, 4'd4, 1'b0);

    // async reset while a result is held; last_grant is 0 here
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("arst.valid", {63'd0, rsp_valid}, 64'd0);
    chk("arst.result", rsp_result, 64'd0);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1 chk("arst.ready", {62'd0, req_ready}, 64'd1);
    tick();
    chk_rsp("arst.first", 64'd3, 1'b0, 4'd4, 1'b0);

    req_valid = 2'b00;
    tick();
    chk("idle.valid", {63'd0, rsp_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 64-bit integer ALU between two requesters, for example the execute stage and the address/branch-compare path. Each requester presents an operation through a valid/ready handshake. A round-robin arbiter picks one request per cycle, evaluates it, and holds the result in a one-entry output register that also has a valid/ready handshake. The block consumes the team's 4-bit ALU control codes, the same codes the ALU decoder produces.

Parameters:
XLEN, 64, operand and result width; must be a power of two and at least 32.
TAG_W, 4, width of the opaque requester tag, returned unchanged with the result.

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush: drop the held result; no grant in this cycle
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept; the request is taken when valid and ready are both 1
req_op  in  2x4  per-requester ALU control code
req_a  in  2xXLEN  per-requester operand A
req_b  in  2xXLEN  per-requester operand B
req_tag  in  2xTAG_W  per-requester tag
rsp_valid  out  1  result register holds a valid result
rsp_ready  in  1  downstream accepts the result
rsp_result  out  XLEN  ALU result
rsp_src  out  1  index of the requester that was served
rsp_tag  out  TAG_W  tag of the served request
rsp_illegal  out  1  the served op code was not a legal code

Behaviour:
- Reset values:
  - rsp_valid, rsp_result, rsp_src, rsp_tag and rsp_illegal are all 0.
  - The round-robin pointer last_grant is 1, so requester 0 wins the first contention.
- can_accept = !flush && (!rsp_valid || rsp_ready).
- Grant selection:
  - Only one requester valid: it is granted.
  - Both valid: grant goes to the requester that is not last_grant.
- req_ready[i] = can_accept && grant[i].
  - At most one bit of req_ready is set.
  - req_ready depends on req_valid, the pointer, rsp_valid, rsp_ready and flush only. It never depends on op, operand or tag values.
- When a request is accepted:
  - The result, source, tag and illegal flag are registered.
  - rsp_valid is 1 on the next cycle, giving a latency of one cycle.
  - last_grant takes the index of the accepted requester.
- The pointer changes only when a request is accepted. It is unchanged by idle cycles, stalls and flush.
- Backpressure: while rsp_valid=1 and rsp_ready=0, every rsp_* output holds stable and req_ready is 0.
- Full throughput: with rsp_ready=1, one result completes per cycle, including back-to-back accepts.
- rsp_valid clears when the result is accepted (rsp_valid && rsp_ready) and no new request is accepted in the same cycle.
- flush=1:
  - rsp_valid goes to 0 on the next cycle.
  - The rsp_* data outputs keep their old values.
  - No request is accepted; this takes priority over a simultaneous rsp_ready.
- Reset asserted mid-operation: all state returns to its reset value immediately. Any pending result is lost.
- Arithmetic, by op code:
  - 0010 ADD and 0110 SUB: modulo 2^XLEN.
  - 0000 AND, 0001 OR, 1000 XOR: bitwise.
  - 0111 SLT: signed compare; result is 1 or 0, zero-extended.
  - 1100 SLTU: unsigned compare; result is 1 or 0, zero-extended.
  - 1001 SLL, 1010 SRL, 1011 SRA: shift amount is b[log2(XLEN)-1:0]; SRA replicates a[XLEN-1].
- Any other code, including 1111: rsp_result=0 and rsp_illegal=1. The request is still consumed and still advances the pointer.

Decomposition:
- Shared package (alu_pkg):
  - the ALU control code constants (AND, OR, ADD, SUB, SLT, XOR, SLL, SRL, SRA, SLTU, INV);
  - an is_legal_op function.
  - The ALU decoder and this block both use this package.
- Sub-module alu_exec: combinational; inputs op, a, b; outputs result and illegal.
- The round-robin selection and the output register stay inline in the top module.

Test Plan:
- Reset release, requester 0 only: op=ADD, a=5, b=7, tag=3 → req_ready[0]=1; next cycle rsp_valid=1, rsp_result=12, rsp_src=0, rsp_tag=3, rsp_illegal=0.
- Both requesters valid continuously with rsp_ready=1 → grants go 0,1,0,1,…, one result per cycle. Check SUB 0−1 gives all ones and SRA of 0x8000_0000_0000_0000 by 63 gives all ones.
- rsp_ready=0 for 3 cycles while a result is held → rsp_* stable and req_ready=00 throughout. After rsp_ready returns to 1, the next request completes one cycle later.
- SLT with a=−1, b=1 gives 1. SLTU with the same operands gives 0. SLL with b=64 (shift amount 0) gives a unchanged. Op 1111 gives result 0 with rsp_illegal=1, and the pointer advances.
- flush asserted together with rsp_ready=1 and both requesters valid → nothing accepted and rsp_valid=0 next cycle. After the flush, the requester that was not last granted wins.
- rst_n pulsed low while rsp_valid=1 → rsp_valid drops to 0 immediately, without waiting for a clock edge. After release, requester 0 wins contention.
